// File: rtl/nn_pkg.sv
// Shared types and helpers for the output-layer datapath.
// Used by the layer packer and its bus interface.
package nn_pkg;

  localparam int FRAME_CNT_W = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } packer_state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/layer_packer_if.sv
// Serial activation stream in, packed frame strobe out.
// master = neuron side, slave = packer.
interface layer_packer_if #(
  parameter int numInput   = 10,
  parameter int inputWidth = 16
);

  logic [inputWidth-1:0]          s_data;
  logic                           s_valid;
  logic                           s_last;
  logic                           s_ready;
  logic [numInput*inputWidth-1:0] o_data;
  logic                           o_valid;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready,
    input  o_data,
    input  o_valid
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready,
    output o_data,
    output o_valid
  );

endinterface

// File: rtl/layer_packer.sv
// Packs serial per-neuron activations into one frame vector
// and strobes it to the argmax stage with a guaranteed gap.
module layer_packer
  import nn_pkg::*;
#(
  parameter int numInput   = 10,
  parameter int inputWidth = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  layer_packer_if.slave          bus,
  output logic                   frame_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int IDX_W = clog2(numInput);
  localparam int VW    = numInput * inputWidth;
  localparam int LO    = (numInput - 1) * inputWidth;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numInput - 1);

  packer_state_t          state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [VW-1:0]          buf_q;
  logic [VW-1:0]          odata_q;
  logic                   ovalid_q;
  logic                   ready_q;
  logic                   err_q;
  logic [FRAME_CNT_W-1:0] cnt_q;

  logic          xfer;
  logic          at_last;
  logic [VW-1:0] frame_d;

  assign xfer    = bus.s_valid & ready_q;
  assign at_last = (idx_q == LAST_IDX);

  // final word bypasses the buffer so the frame lands in one edge
  always_comb begin
    frame_d = buf_q;
    frame_d[LO +: inputWidth] = bus.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      idx_q    <= '0;
      buf_q    <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ovalid_q <= 1'b0;
      ready_q  <= 1'b1;
      unique case (state_q)
        COLLECT: begin
          if (xfer) begin
            unique case (1'b1)
              (at_last && bus.s_last): begin
                odata_q  <= frame_d;
                ovalid_q <= 1'b1;
                cnt_q    <= cnt_q + 1'b1;
                idx_q    <= '0;
                ready_q  <= 1'b0;
                state_q  <= EMIT;
              end
              (at_last != bus.s_last): begin
                err_q <= 1'b1;
                idx_q <= '0;
              end
              default: begin
                buf_q[int'(idx_q)*inputWidth +: inputWidth] <= bus.s_data;
                idx_q <= idx_q + 1'b1;
              end
            endcase
          end
        end
        EMIT: begin
          state_q <= COLLECT;
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign bus.s_ready = ready_q;
  assign bus.o_data  = odata_q;
  assign bus.o_valid = ovalid_q;
  assign frame_err   = err_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_layer_packer.sv
// Directed bench for layer_packer: framing, stalls,
// back-to-back spacing, framing errors and async reset.
module tb_layer_packer;
  import nn_pkg::*;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int VW = N * W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int npass  = 0;
  int ncheck = 0;
  int cyc    = 0;
  int npulse = 0;
  int pt[$];

  layer_packer_if #(.numInput(N), .inputWidth(W)) bus ();

  layer_packer #(
    .numInput  (N),
    .inputWidth(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.o_valid === 1'b1) begin
      npulse = npulse + 1;
      pt.push_back(cyc);
    end

  task automatic chk(string tag, logic [VW-1:0] got,
                     logic [VW-1:0] exp);
    ncheck++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [VW-1:0] exp_frame(logic [W-1:0] b);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = b + W'(i);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    #1;
    chk("rst_odata", bus.o_data, '0);
    chk("rst_ovalid", VW'(bus.o_valid), '0);
    chk("rst_err", VW'(frame_err), '0);
    chk("rst_cnt", VW'(frame_cnt), '0);
    chk("rst_ready", VW'(bus.s_ready), '0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    npulse = 0;
    pt.delete();
  endtask

  task automatic send(logic [W-1:0] d, logic l);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("ready_timeout", VW'(bus.s_ready), VW'(1));
    @(negedge clk);
  endtask

  task automatic send_frame(logic [W-1:0] base, int stall_after);
    for (int i = 0; i < N; i++) begin
      send(base + W'(i), (i == N - 1));
      if (i == stall_after) begin
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int d;
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // basic frame
    do_reset();
    send_frame(16'h0001, -1);
    chk("basic_ovalid", VW'(bus.o_valid), VW'(1));
    chk("basic_lo", VW'(bus.o_data[15:0]), VW'(16'h0001));
    chk("basic_hi", VW'(bus.o_data[159:144]), VW'(16'h000A));
    chk("basic_data", bus.o_data, exp_frame(16'h0001));
    chk("basic_cnt", VW'(frame_cnt), VW'(1));
    chk("basic_ready", VW'(bus.s_ready), '0);
    chk("basic_err", VW'(frame_err), '0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("basic_vdrop", VW'(bus.o_valid), '0);
    chk("basic_hold", bus.o_data, exp_frame(16'h0001));

    // stalled frame
    do_reset();
    send_frame(16'h0001, 3);
    chk("stall_ovalid", VW'(bus.o_valid), VW'(1));
    chk("stall_data", bus.o_data, exp_frame(16'h0001));
    bus.s_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stall_pulses", VW'(npulse), VW'(1));

    // back-to-back frames
    do_reset();
    send_frame(16'h0100, -1);
    chk("b2b_ready0", VW'(bus.s_ready), '0);
    chk("b2b_data0", bus.o_data, exp_frame(16'h0100));
    send_frame(16'h0200, -1);
    chk("b2b_ready1", VW'(bus.s_ready), '0);
    chk("b2b_data1", bus.o_data, exp_frame(16'h0200));
    chk("b2b_cnt", VW'(frame_cnt), VW'(2));
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("b2b_pulses", VW'(npulse), VW'(2));
    d = (pt.size() >= 2) ? pt[1] - pt[0] : 0;
    chk("b2b_gap", VW'(d), VW'(11));

    // early last
    do_reset();
    for (int i = 0; i < 7; i++) send(16'h00A0 + W'(i), (i == 6));
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("early_err", VW'(frame_err), VW'(1));
    chk("early_nopulse", VW'(npulse), '0);
    chk("early_cnt0", VW'(frame_cnt), '0);
    send_frame(16'h0300, -1);
    chk("early_ovalid", VW'(bus.o_valid), VW'(1));
    chk("early_data", bus.o_data, exp_frame(16'h0300));
    chk("early_cnt1", VW'(frame_cnt), VW'(1));
    chk("early_sticky", VW'(frame_err), VW'(1));
    bus.s_valid = 1'b0;

    // missing last
    do_reset();
    for (int i = 0; i < N; i++) send(16'h0400 + W'(i), 1'b0);
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("miss_err", VW'(frame_err), VW'(1));
    chk("miss_nopulse", VW'(npulse), '0);
    send_frame(16'h0500, -1);
    chk("miss_data", bus.o_data, exp_frame(16'h0500));
    chk("miss_cnt", VW'(frame_cnt), VW'(1));
    bus.s_valid = 1'b0;

    // reset mid-frame, after a frame left o_data non-zero
    do_reset();
    send_frame(16'h0600, -1);
    for (int i = 0; i < 5; i++) send(16'h0700 + W'(i), 1'b0);
    do_reset();
    send_frame(16'h0800, -1);
    chk("mid_ovalid", VW'(bus.o_valid), VW'(1));
    chk("mid_data", bus.o_data, exp_frame(16'h0800));
    chk("mid_cnt", VW'(frame_cnt), VW'(1));
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
